// File: rtl/odyssey_video_timing.sv
// Raster timing generator: pixel enable, h/v counters, sync and blank flags, NTSC/PAL geometry.
// Optional frame counter enabled by defining ODYSSEY_VT_FRAME_CNT_EN.
module odyssey_video_timing #(
    parameter int CE_DIV   = 4,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 320,
    parameter int HS_START = 336,
    parameter int HS_END   = 364,
    parameter int V_ACTIVE = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic [8:0] hcount,
    output logic [8:0] vcount,
    output logic       line_dbl,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic       new_frame,
    output logic [7:0] frame_cnt
);

    localparam int DW = $clog2(CE_DIV);
    localparam logic [DW-1:0] DIV_FULL_LAST = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF_LAST = DW'(CE_DIV / 2 - 1);
    localparam logic [8:0]    H_LAST        = 9'(H_TOTAL - 1);

    generate
        if (H_TOTAL > 512 || HS_END > H_TOTAL || V_ACTIVE >= 244 ||
            CE_DIV < 2 || (CE_DIV % 2) != 0) begin : g_param_check
            $error("odyssey_video_timing: illegal parameter set");
        end
    endgenerate

    logic [DW-1:0] div;
    logic [DW-1:0] div_last;
    logic          pal_q;
    logic          sd_q;
    logic          ce;
    logic          line_end;
    logic          line_adv;
    logic          frame_wrap;
    logic [8:0]    v_last;

    always_comb begin
        div_last   = sd_q ? DIV_HALF_LAST : DIV_FULL_LAST;
        v_last     = pal_q ? 9'd311 : 9'd261;
        ce         = (div == div_last);
        line_end   = ce && (hcount == H_LAST);
        // in line-doubled mode the source line only advances after its second copy
        line_adv   = line_end && (!sd_q || line_dbl);
        frame_wrap = line_adv && (vcount == v_last);
        ce_pix     = ce && !reset;
        new_frame  = frame_wrap && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div      <= '0;
            hcount   <= '0;
            vcount   <= '0;
            line_dbl <= 1'b0;
            pal_q    <= pal;
            sd_q     <= scandouble;
        end else begin
            div <= ce ? '0 : div + DW'(1);
            if (ce) begin
                hcount <= line_end ? 9'd0 : hcount + 9'd1;
                if (line_end) begin
                    line_dbl <= sd_q ? ~line_dbl : 1'b0;
                    if (line_adv) begin
                        vcount <= frame_wrap ? 9'd0 : vcount + 9'd1;
                    end
                end
            end
            if (frame_wrap) begin
                pal_q <= pal;
                sd_q  <= scandouble;
            end
        end
    end

    always_comb begin
        HBlank = (hcount >= 9'(H_ACTIVE));
        HSync  = (hcount >= 9'(HS_START)) && (hcount < 9'(HS_END));
        VBlank = (vcount >= 9'(V_ACTIVE));
        VSync  = pal_q ? ((vcount >= 9'd270) && (vcount <= 9'd272))
                       : ((vcount >= 9'd244) && (vcount <= 9'd246));
    end

`ifdef ODYSSEY_VT_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_odyssey_video_timing.sv
// Scoreboard bench for odyssey_video_timing: a clock-accurate raster model pushes expected
// pixel events, a monitor pops and compares them whenever the DUT raises ce_pix.
module tb_odyssey_video_timing;

    localparam int CE_DIV   = 2;
    localparam int H_TOTAL  = 10;
    localparam int H_ACTIVE = 7;
    localparam int HS_START = 8;
    localparam int HS_END   = 9;
    localparam int V_ACTIVE = 240;
`ifdef ODYSSEY_VT_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pal = 1'b0;
    logic       scandouble = 1'b0;
    logic       ce_pix;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       line_dbl;
    logic       HBlank, HSync, VBlank, VSync;
    logic       new_frame;
    logic [7:0] frame_cnt;

    odyssey_video_timing #(
        .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
        .HS_START(HS_START), .HS_END(HS_END), .V_ACTIVE(V_ACTIVE)
    ) dut (
        .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
        .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .line_dbl(line_dbl),
        .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank), .VSync(VSync),
        .new_frame(new_frame), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int h; int v; int ld; int nf;
        int hb; int hs; int vb; int vs; int fc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc_now = 0;
    bit   rst_seen = 1'b0;

    // model state: clock index within the current frame and the mode latched for it
    int   t = 0;
    bit   pal_m = 1'b0;
    bit   sd_m = 1'b0;
    int   frames = 0;
    bit   model_ok = 1'b0;
    bit   r_s, pal_s, sd_s;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at cycle %0d", name, act, req, cyc_now);
        end
    endtask

    function automatic int dval();
        return sd_m ? CE_DIV / 2 : CE_DIV;
    endfunction

    function automatic int pulses_per_frame();
        return (pal_m ? 312 : 262) * H_TOTAL * (sd_m ? 2 : 1);
    endfunction

    always @(posedge clk) begin
        cyc_now  <= cyc_now + 1;
        rst_seen <= reset;
    end

    always begin
        exp_t e;
        int   p, line;
        @(posedge clk);
        r_s   = reset;
        pal_s = pal;
        sd_s  = scandouble;
        #2;
        if (r_s) begin
            t = 0; pal_m = pal_s; sd_m = sd_s; frames = 0;
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (t == pulses_per_frame() * dval() - 1) begin
                t = 0; pal_m = pal_s; sd_m = sd_s; frames++;
            end else begin
                t++;
            end
        end
        if (model_ok && !reset && (t % dval()) == dval() - 1) begin
            p     = t / dval();
            line  = p / H_TOTAL;
            e.cyc = cyc_now;
            e.h   = p % H_TOTAL;
            e.v   = sd_m ? line / 2 : line;
            e.ld  = sd_m ? line % 2 : 0;
            e.nf  = (p == pulses_per_frame() - 1) ? 1 : 0;
            e.hb  = (e.h >= H_ACTIVE) ? 1 : 0;
            e.hs  = (e.h >= HS_START && e.h < HS_END) ? 1 : 0;
            e.vb  = (e.v >= V_ACTIVE) ? 1 : 0;
            e.vs  = pal_m ? ((e.v >= 270 && e.v <= 272) ? 1 : 0)
                          : ((e.v >= 244 && e.v <= 246) ? 1 : 0);
            e.fc  = FC_EN ? frames % 256 : 0;
            q.push_back(e);
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_seen) begin
            chk("rst_hcount", int'(hcount), 0);
            chk("rst_vcount", int'(vcount), 0);
            chk("rst_line_dbl", int'(line_dbl), 0);
            chk("rst_flags", int'({HBlank, HSync, VBlank, VSync}), 0);
            chk("rst_frame_cnt", int'(frame_cnt), 0);
            if (reset) begin
                chk("rst_ce_pix", int'(ce_pix), 0);
                chk("rst_new_frame", int'(new_frame), 0);
            end
        end
        if (!reset && ce_pix) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ce_unexpected: actual ce_pix=1 required none at cycle %0d", cyc_now);
            end else begin
                e = q.pop_front();
                chk("ce_cycle", cyc_now, e.cyc);
                chk("hcount", int'(hcount), e.h);
                chk("vcount", int'(vcount), e.v);
                chk("line_dbl", int'(line_dbl), e.ld);
                chk("new_frame", int'(new_frame), e.nf);
                chk("HBlank", int'(HBlank), e.hb);
                chk("HSync", int'(HSync), e.hs);
                chk("VBlank", int'(VBlank), e.vb);
                chk("VSync", int'(VSync), e.vs);
                chk("frame_cnt", int'(frame_cnt), e.fc);
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event within budget", name);
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 15000 && !found; i++) begin
            @(negedge clk);
            if (int'(hcount) == h && int'(vcount) == v) found = 1'b1;
        end
        if (!found) timeout(name);
        @(posedge clk);
        #1;
    endtask

    // lands in the wrap cycle itself when the current frame runs at the full divider
    task automatic wait_frame_last_pixel(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 15000 && !found; i++) begin
            @(negedge clk);
            if (int'(hcount) == H_TOTAL - 1 && int'(vcount) == (pal_m ? 311 : 261) && !ce_pix)
                found = 1'b1;
        end
        if (!found) timeout(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        run(3);
        reset = 1'b0;
        run(6000);

        wait_pos(0, 100, "wait_v100");
        pal = 1'b1;
        run(10000);

        wait_frame_last_pixel("wait_wrap");
        scandouble = 1'b1;
        pal = 1'b0;
        run(6000);

        wait_pos(5, 50, "wait_h5_v50");
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(300);

        for (int i = 0; i < 10; i++) begin
            int act;
            run($urandom_range(200, 2500));
            act = $urandom_range(0, 3);
            case (act)
                0: pal = ~pal;
                1: scandouble = ~scandouble;
                2: begin pal = ~pal; scandouble = ~scandouble; end
                default: begin
                    reset = 1'b1;
                    run(1);
                    reset = 1'b0;
                end
            endcase
        end

        run(50);
        chk("queue_drained", (q.size() <= 1) ? 1 : 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
